// File: rtl/modulo_pkg.sv
// Shared definitions for the modulo-ADC recovery chain.
//   DEF_LAMBDA / DEF_WIDTH : default fold threshold and sample width
//   err_flags_t            : the four sticky error flags of the unfold stage
//   sat_add                : signed add, saturated to a given width, with saturation flag
package modulo_pkg;

    localparam int DEF_LAMBDA = 10;
    localparam int DEF_WIDTH  = 16;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic range_err;
        logic saturate;
    } err_flags_t;

    // Operands are pre-sign-extended to 64 bits; the 65-bit sum cannot wrap, so the
    // comparison against the width limits is exact. Caller truncates to `width` bits.
    function automatic logic signed [63:0] sat_add(
        input  logic signed [63:0] a,
        input  logic signed [63:0] b,
        input  int unsigned        width,
        output logic               sat
    );
        logic signed [64:0] sum;
        logic signed [64:0] max_v;
        logic signed [64:0] min_v;
        sum   = {a[63], a} + {b[63], b};
        max_v = (65'sd1 <<< (width - 1)) - 65'sd1;
        min_v = -(65'sd1 <<< (width - 1));
        sat   = 1'b0;
        if (sum > max_v) begin
            sat = 1'b1;
            sum = max_v;
        end else if (sum < min_v) begin
            sat = 1'b1;
            sum = min_v;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/sample_align_fifo.sv
// Alignment FIFO holding folded samples until their residual arrives.
//   clk, reset (async, active-low), clear (sync flush, wins over push/pop)
//   push/wdata : write request; ignored when full unless a pop happens the same cycle
//   pop/rdata  : read request; rdata shows the head entry combinationally
//   full, empty, level : occupancy status
module sample_align_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_en, pop_en;

    assign full    = (level_q == FullLevel);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem[rd_ptr_q];
    assign pop_en  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_en = push && (!full || pop_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push_en, pop_en})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !clear) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/modulo_unfold_accum.sv
// Modulo-ADC unfold stage: integrates folding corrections into a running offset and
// adds it to the matching folded sample, emitting saturated reconstructed samples.
//   clk, reset (async, active-low), clear (sync flush of accumulator/FIFO/pipeline/flags)
//   sample_valid/sample_in : folded sample y[k] into the alignment FIFO
//   valid_in/residual_in   : correction r[k]; pops one sample when the FIFO is non-empty
//   valid_out/recon_out    : y[k] + eps[k], two cycles after the accepted residual
//   fifo_level             : alignment FIFO occupancy
//   err_*                  : sticky overflow / underflow / range / saturation flags
module modulo_unfold_accum
    import modulo_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned OUT_WIDTH  = 24,
    parameter int          LAMBDA     = DEF_LAMBDA,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_valid,
    input  logic signed [WIDTH-1:0]       sample_in,
    input  logic                          valid_in,
    input  logic signed [WIDTH-1:0]       residual_in,
    input  logic                          clear,
    output logic                          valid_out,
    output logic signed [OUT_WIDTH-1:0]   recon_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_overflow,
    output logic                          err_underflow,
    output logic                          err_range,
    output logic                          err_sat
);
    logic                        fifo_full, fifo_empty, accept;
    logic [WIDTH-1:0]            fifo_rdata;

    logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0]     s1_sample_q;
    logic                        s1_valid_q;
    logic signed [OUT_WIDTH-1:0] recon_q, recon_d;
    logic                        out_valid_q;
    err_flags_t                  err_q, err_d;

    logic signed [63:0]          res64, acc64, smp64;
    logic                        acc_sat, recon_sat, range_ok;

    // Residual k may only consume a sample already stored at the start of the cycle.
    assign accept = valid_in && !fifo_empty;

    sample_align_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (sample_valid),
        .pop   (accept),
        .wdata (sample_in),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        res64    = {{(64 - WIDTH){residual_in[WIDTH-1]}}, residual_in};
        acc64    = {{(64 - OUT_WIDTH){acc_q[OUT_WIDTH-1]}}, acc_q};
        smp64    = {{(64 - WIDTH){s1_sample_q[WIDTH-1]}}, s1_sample_q};
        acc_sat  = 1'b0;
        recon_sat = 1'b0;
        acc_d    = OUT_WIDTH'(sat_add(acc64, res64, OUT_WIDTH, acc_sat));
        // S2 uses acc_q, which already holds the offset including residual k.
        recon_d  = OUT_WIDTH'(sat_add(smp64, acc64, OUT_WIDTH, recon_sat));
        range_ok = (res64 == 64'sd0) || (res64 == longint'(2 * LAMBDA)) ||
                   (res64 == -longint'(2 * LAMBDA));

        err_d = err_q;
        if (sample_valid && fifo_full && !accept) err_d.overflow  = 1'b1;
        if (valid_in && fifo_empty)               err_d.underflow = 1'b1;
        if (accept && !range_ok)                  err_d.range_err = 1'b1;
        if ((accept && acc_sat) || (s1_valid_q && recon_sat)) err_d.saturate = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            s1_sample_q <= '0;
            s1_valid_q  <= 1'b0;
            recon_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= '0;
        end else if (clear) begin
            acc_q       <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= '0;
        end else begin
            s1_valid_q  <= accept;
            if (accept) begin
                acc_q       <= acc_d;
                s1_sample_q <= fifo_rdata;
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) recon_q <= recon_d;
            err_q       <= err_d;
        end
    end

    assign valid_out     = out_valid_q;
    assign recon_out     = recon_q;
    assign err_overflow  = err_q.overflow;
    assign err_underflow = err_q.underflow;
    assign err_range     = err_q.range_err;
    assign err_sat       = err_q.saturate;

endmodule
